mole_scheduler: RTL and testbench
=================================

// Module: mole_scheduler
// PURPOSE
//  Parametrised successor to the single-mole picker. Picks a pseudo-random hole
//  and a random up-time, holds it for that time, and reports hit or miss. Then
//  inserts a gap and picks again while enable is high.
//  Sits between the game controller (enable, hit) and the LED/score logic
//  (mole_onehot, hit_ok, miss).
// PARAMETERS
//  NUM_HOLES      8          number of holes, 2..16; need not be a power of 2
//  HOLE_W         3          width of hole index, >= clog2(NUM_HOLES)
//  TIME_W         3          width of moletime, in time units
//  TICKS_PER_UNIT 50000000   CLK100MHZ cycles per time unit (0.5 s)
//  GAP_TICKS      25000000   cycles with all moles off between picks
//  LFSR_W         16         LFSR width
//  SEED           16'hACE1   LFSR reset value; must be non-zero
// PORTS
//  CLK100MHZ    in   1          system clock; all logic on the rising edge
//  reset        in   1          synchronous, active-high
//  enable       in   1          game running
//  hit_valid    in   1          one-cycle strobe: player struck hit_hole
//  hit_hole     in   HOLE_W     hole that was struck
//  pastenable   out  1          enable registered one cycle
//  mole_valid   out  1          a mole is up (state SHOW)
//  mole         out  HOLE_W     index of the active hole
//  moletime     out  TIME_W     up-time of the current mole, in units (never 0)
//  mole_onehot  out  NUM_HOLES  LED drive: 1<<mole while mole_valid, else 0
//  hit_ok       out  1          one-cycle pulse: correct hole struck
//  miss         out  1          one-cycle pulse: mole timed out unhit
// BEHAVIOUR
//  Reset:
//   - all outputs 0; state IDLE; LFSR=SEED.
//   - internal last_hole=NUM_HOLES (invalid, so the first pick never collides).
//  LFSR:
//   - Galois, maximal-length taps, advances every cycle outside reset.
//   - If the value ever reaches 0, it reloads SEED.
//  FSM IDLE -> PICK -> SHOW -> GAP -> PICK ...
//   - IDLE: move to PICK on the enable rising edge (enable & ~pastenable).
//   - PICK: cand = lfsr[HOLE_W-1:0].
//     - cand >= NUM_HOLES: reject, retry next cycle.
//     - Otherwise latch mole=cand and moletime=lfsr[HOLE_W+:TIME_W].
//     - If that field is 0, moletime=1.
//     - Load unit counter=moletime and prescaler=TICKS_PER_UNIT-1; go to SHOW.
//   - SHOW: prescaler counts down; at 0 it reloads and units decrements.
//     - hit_valid & hit_hole==mole: hit_ok=1 for one cycle, go to GAP.
//     - units reaching 0 at a prescaler wrap: miss=1 for one cycle, go to GAP.
//     - Hit and timeout in the same cycle: hit wins, no miss.
//     - Wrong-hole hits, and any hit outside SHOW, are ignored.
//   - GAP: outputs off, count GAP_TICKS cycles, then go to PICK.
//     - On entry to GAP: last_hole=mole.
//  Timing and abort:
//   - mole_valid/mole_onehot rise the cycle after the PICK accept.
//   - They fall the cycle after the hit or timeout.
//   - enable low in any state: next cycle IDLE.
//     - mole_valid, mole_onehot, hit_ok and miss are forced to 0.
//     - mole and moletime hold their last values.
//   - reset mid-SHOW: reset state next edge, no miss pulse.
//  Widths: counters sized with clog2 of their maximum value; no truncation
//  warnings are allowed.
// CONFIGURATION
//  MOLE_NO_REPEAT_EN defined:
//   - PICK also rejects cand==last_hole; consecutive moles always differ.
//   - Requires NUM_HOLES >= 2.
//  MOLE_NO_REPEAT_EN undefined:
//   - last_hole logic is not compiled; repeats are allowed.
// STRUCTURE
//  mole_pkg: FSM state encodings (IDLE/PICK/SHOW/GAP), LFSR tap constants per
//  LFSR_W, and a clog2 function.
//  Sub-module lfsr_gen (params LFSR_W and SEED; ports CLK100MHZ, reset,
//  lfsr_out) holds the LFSR; the FSM and counters stay in this module.
// TESTING
//  Simulation config: TICKS_PER_UNIT=4, GAP_TICKS=3, NUM_HOLES=8.
//  1 reset=1 for 2 cycles -> all outputs 0; lfsr_gen output=16'hACE1.
//  2 enable rises, no hit -> mole_valid=1 for exactly moletime*4 cycles, then
//    one miss pulse, 3 gap cycles, next mole.
//  3 hit_valid with hit_hole=mole, 2 cycles into SHOW -> hit_ok pulse next
//    cycle; mole_onehot=0 the cycle after.
//  4 hit with a wrong hole, then hit on the final timeout cycle with the right
//    hole -> wrong hit ignored; hit_ok=1, miss=0.
//  5 NUM_HOLES=5, 200 picks -> mole<5 always; moletime in 1..7.
//    With MOLE_NO_REPEAT_EN, no two consecutive moles are equal.
//  6 enable drops mid-SHOW -> next cycle IDLE, mole_valid=0, no miss.
//    Re-raising enable starts a new PICK.

Source files
------------

// File: rtl/mole_pkg.sv
// Shared types and helpers for the whack-a-mole scheduler.
// FSM encodings, Galois LFSR tap masks and a constant clog2.
package mole_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PICK,
    S_SHOW,
    S_GAP
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Right-shifting Galois masks, maximal length
  function automatic logic [31:0] lfsr_taps(input int w);
    logic [31:0] t;
    unique case (w)
      3:       t = 32'h0000_0006;
      4:       t = 32'h0000_000C;
      5:       t = 32'h0000_0014;
      6:       t = 32'h0000_0030;
      7:       t = 32'h0000_0060;
      8:       t = 32'h0000_00B8;
      9:       t = 32'h0000_0110;
      10:      t = 32'h0000_0240;
      11:      t = 32'h0000_0500;
      12:      t = 32'h0000_0E08;
      13:      t = 32'h0000_1C80;
      14:      t = 32'h0000_3802;
      15:      t = 32'h0000_6000;
      16:      t = 32'h0000_B400;
      17:      t = 32'h0001_2000;
      18:      t = 32'h0002_0400;
      19:      t = 32'h0007_2000;
      20:      t = 32'h0009_0000;
      24:      t = 32'h00E1_0000;
      32:      t = 32'hA300_0000;
      default: t = 32'h0000_B400;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Free-running Galois LFSR; reloads SEED if it ever collapses to zero.
module lfsr_gen
  import mole_pkg::*;
#(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(16'hACE1)
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  output logic [LFSR_W-1:0] lfsr_out
);

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

  logic [LFSR_W-1:0] r_lfsr;
  logic [LFSR_W-1:0] w_step;

  always_comb begin
    w_step = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_lfsr <= SEED;
    end else if (r_lfsr == '0) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= w_step;
    end
  end

  assign lfsr_out = r_lfsr;

endmodule

// File: rtl/mole_scheduler.sv
// Mole picker/timer: IDLE -> PICK -> SHOW -> GAP -> PICK while enabled.
// MOLE_NO_REPEAT_EN: forbid the same hole twice in a row.
module mole_scheduler
  import mole_pkg::*;
#(
  parameter int                NUM_HOLES      = 8,
  parameter int                HOLE_W         = 3,
  parameter int                TIME_W         = 3,
  parameter int                TICKS_PER_UNIT = 50000000,
  parameter int                GAP_TICKS      = 25000000,
  parameter int                LFSR_W         = 16,
  parameter logic [LFSR_W-1:0] SEED           = LFSR_W'(16'hACE1)
) (
  input  logic                 CLK100MHZ,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 hit_valid,
  input  logic [HOLE_W-1:0]    hit_hole,
  output logic                 pastenable,
  output logic                 mole_valid,
  output logic [HOLE_W-1:0]    mole,
  output logic [TIME_W-1:0]    moletime,
  output logic [NUM_HOLES-1:0] mole_onehot,
  output logic                 hit_ok,
  output logic                 miss
);

  localparam int PW = (clog2(TICKS_PER_UNIT) < 1) ? 1 : clog2(TICKS_PER_UNIT);
  localparam int GW = (clog2(GAP_TICKS) < 1) ? 1 : clog2(GAP_TICKS);
  localparam logic [PW-1:0]   PRE_MAX = PW'(TICKS_PER_UNIT - 1);
  localparam logic [GW-1:0]   GAP_MAX = GW'(GAP_TICKS - 1);
  localparam logic [HOLE_W:0] NH      = (HOLE_W + 1)'(NUM_HOLES);

  state_t r_state;
  state_t w_next;

  logic              r_pastenable;
  logic [HOLE_W-1:0] r_mole;
  logic [TIME_W-1:0] r_moletime;
  logic [TIME_W-1:0] r_units;
  logic [PW-1:0]     r_pre;
  logic [GW-1:0]     r_gap;
  logic              r_hit_ok;
  logic              r_miss;

  logic [LFSR_W-1:0] w_lfsr;
  logic [HOLE_W-1:0] w_cand;
  logic [TIME_W-1:0] w_tfield;
  logic [TIME_W-1:0] w_time;
  logic              w_reject;
  logic              w_rise;
  logic              w_hit;
  logic              w_wrap;
  logic              w_tout;
  logic              w_accept;
  logic              w_hit_ev;
  logic              w_miss_ev;
  logic              w_unused;

`ifdef MOLE_NO_REPEAT_EN
  logic [HOLE_W:0]   r_last;
`endif

  lfsr_gen #(
    .LFSR_W (LFSR_W),
    .SEED   (SEED)
  ) u_lfsr (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .lfsr_out  (w_lfsr)
  );

  assign w_unused = ^w_lfsr;

  always_comb begin
    w_cand   = w_lfsr[HOLE_W-1:0];
    w_tfield = w_lfsr[HOLE_W +: TIME_W];
    w_time   = (w_tfield == '0) ? TIME_W'(1) : w_tfield;
    w_reject = ({1'b0, w_cand} >= NH);
`ifdef MOLE_NO_REPEAT_EN
    w_reject = w_reject | ({1'b0, w_cand} == r_last);
`endif
    w_rise   = enable & ~r_pastenable;
    w_hit    = hit_valid & (hit_hole == r_mole);
    w_wrap   = (r_pre == '0);
    w_tout   = w_wrap & (r_units == TIME_W'(1));
  end

  // Enable low overrides every state; hit beats a coincident timeout
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_hit_ev  = 1'b0;
    w_miss_ev = 1'b0;
    if (!enable) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_rise) w_next = S_PICK;
        end
        S_PICK: begin
          if (!w_reject) begin
            w_next   = S_SHOW;
            w_accept = 1'b1;
          end
        end
        S_SHOW: begin
          if (w_hit) begin
            w_next   = S_GAP;
            w_hit_ev = 1'b1;
          end else if (w_tout) begin
            w_next    = S_GAP;
            w_miss_ev = 1'b1;
          end
        end
        S_GAP: begin
          if (r_gap == '0) w_next = S_PICK;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_pastenable <= 1'b0;
      r_mole       <= '0;
      r_moletime   <= '0;
      r_units      <= '0;
      r_pre        <= '0;
      r_gap        <= '0;
      r_hit_ok     <= 1'b0;
      r_miss       <= 1'b0;
`ifdef MOLE_NO_REPEAT_EN
      r_last       <= NH;
`endif
    end else begin
      r_state      <= w_next;
      r_pastenable <= enable;
      r_hit_ok     <= w_hit_ev;
      r_miss       <= w_miss_ev;
      if (w_accept) begin
        r_mole     <= w_cand;
        r_moletime <= w_time;
        r_units    <= w_time;
        r_pre      <= PRE_MAX;
      end else if (r_state == S_SHOW) begin
        if (w_wrap) begin
          r_pre   <= PRE_MAX;
          r_units <= r_units - TIME_W'(1);
        end else begin
          r_pre <= r_pre - PW'(1);
        end
      end
      if (w_next == S_GAP && r_state != S_GAP) begin
        r_gap <= GAP_MAX;
      end else if (r_state == S_GAP && r_gap != '0) begin
        r_gap <= r_gap - GW'(1);
      end
`ifdef MOLE_NO_REPEAT_EN
      if (w_hit_ev | w_miss_ev) r_last <= {1'b0, r_mole};
`endif
    end
  end

  always_comb begin
    mole_onehot = '0;
    for (int i = 0; i < NUM_HOLES; i++) begin
      mole_onehot[i] = mole_valid & (r_mole == HOLE_W'(i));
    end
  end

  assign pastenable = r_pastenable;
  assign mole_valid = (r_state == S_SHOW);
  assign mole       = r_mole;
  assign moletime   = r_moletime;
  assign hit_ok     = r_hit_ok;
  assign miss       = r_miss;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler with short unit/gap timing.
module tb_mole_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       enable;
  logic       hit_valid;
  logic [2:0] hit_hole;
  logic       pastenable;
  logic       mole_valid;
  logic [2:0] mole;
  logic [2:0] moletime;
  logic [7:0] mole_onehot;
  logic       hit_ok;
  logic       miss;

  logic       enable5;
  logic       hit_valid5;
  logic [2:0] hit_hole5;
  logic       pastenable5;
  logic       mole_valid5;
  logic [2:0] mole5;
  logic [2:0] moletime5;
  logic [4:0] mole_onehot5;
  logic       hit_ok5;
  logic       miss5;

  int errors = 0;
  int checks = 0;

  mole_scheduler #(
    .NUM_HOLES(8), .HOLE_W(3), .TIME_W(3),
    .TICKS_PER_UNIT(4), .GAP_TICKS(3)
  ) u_dut (
    .CLK100MHZ(clk), .reset(reset), .enable(enable),
    .hit_valid(hit_valid), .hit_hole(hit_hole),
    .pastenable(pastenable), .mole_valid(mole_valid),
    .mole(mole), .moletime(moletime), .mole_onehot(mole_onehot),
    .hit_ok(hit_ok), .miss(miss)
  );

  mole_scheduler #(
    .NUM_HOLES(5), .HOLE_W(3), .TIME_W(3),
    .TICKS_PER_UNIT(4), .GAP_TICKS(3)
  ) u_dut5 (
    .CLK100MHZ(clk), .reset(reset), .enable(enable5),
    .hit_valid(hit_valid5), .hit_hole(hit_hole5),
    .pastenable(pastenable5), .mole_valid(mole_valid5),
    .mole(mole5), .moletime(moletime5), .mole_onehot(mole_onehot5),
    .hit_ok(hit_ok5), .miss(miss5)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic        hv;
    logic [2:0]  hh;
    logic        e_valid;
    logic        e_past;
    logic        e_hit;
    logic        e_miss;
    logic [2:0]  e_mole;
    logic [2:0]  e_time;
    logic [7:0]  e_oh;
    logic [15:0] e_lfsr;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rise(input bit five, input int budget,
                           input string name);
    for (int i = 0; i < budget; i++) begin
      if ((five ? mole_valid5 : mole_valid) == 1'b1) break;
      step();
    end
    chk(name, 32'(five ? mole_valid5 : mole_valid), 32'd1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    int low;
    int m;
    logic [2:0] sv_mole;
    logic [2:0] sv_time;
    logic [2:0] prev5;
    bit bad;

    // rst en hv hh | valid past hit miss mole time oh lfsr
    tbl[0] = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0,
               3'd0, 3'd0, 8'h00, 16'hACE1};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0,
               3'd0, 3'd0, 8'h00, 16'hACE1};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0,
               3'd0, 3'd0, 8'h00, 16'hE270};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0,
               3'd0, 3'd6, 8'h01, 16'h7138};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0,
               3'd0, 3'd6, 8'h01, 16'h389C};

    reset = 1'b1;
    enable = 1'b0;
    hit_valid = 1'b0;
    hit_hole = 3'd0;
    enable5 = 1'b0;
    hit_valid5 = 1'b0;
    hit_hole5 = 3'd0;
    #1;

    for (int i = 0; i < 5; i++) begin
      reset = tbl[i].rst;
      enable = tbl[i].en;
      hit_valid = tbl[i].hv;
      hit_hole = tbl[i].hh;
      step();
      chk($sformatf("v%0d.valid", i), 32'(mole_valid), 32'(tbl[i].e_valid));
      chk($sformatf("v%0d.past", i), 32'(pastenable), 32'(tbl[i].e_past));
      chk($sformatf("v%0d.hit", i), 32'(hit_ok), 32'(tbl[i].e_hit));
      chk($sformatf("v%0d.miss", i), 32'(miss), 32'(tbl[i].e_miss));
      chk($sformatf("v%0d.mole", i), 32'(mole), 32'(tbl[i].e_mole));
      chk($sformatf("v%0d.time", i), 32'(moletime), 32'(tbl[i].e_time));
      chk($sformatf("v%0d.oh", i), 32'(mole_onehot), 32'(tbl[i].e_oh));
      chk($sformatf("v%0d.lfsr", i), 32'(u_dut.u_lfsr.lfsr_out),
          32'(tbl[i].e_lfsr));
    end
    hit_valid = 1'b0;

    // Timeout of the first mole: 6 units of 4 ticks
    cnt = 2;
    for (int i = 0; i < 100; i++) begin
      step();
      if (!mole_valid) break;
      cnt++;
    end
    chk("show_len", 32'(cnt), 32'd24);
    chk("miss_pulse", 32'(miss), 32'd1);
    low = 1;
    step();
    chk("miss_once", 32'(miss), 32'd0);
    if (!mole_valid) low++;
    for (int i = 0; i < 60 && !mole_valid; i++) begin
      step();
      if (!mole_valid) low++;
    end
`ifdef MOLE_NO_REPEAT_EN
    chk("gap_len", 32'(low >= 4 && low < 60), 32'd1);
`else
    chk("gap_len", 32'(low), 32'd4);
`endif
    chk("next_mole", 32'(mole_valid), 32'd1);
    chk("oh_map", 32'(mole_onehot), 32'(8'd1 << mole));
    chk("time_nz", 32'(moletime != 3'd0), 32'd1);

    // Correct hit two cycles into SHOW
    step();
    hit_valid = 1'b1;
    hit_hole = mole;
    step();
    hit_valid = 1'b0;
    chk("hit_ok", 32'(hit_ok), 32'd1);
    chk("hit_miss0", 32'(miss), 32'd0);
    chk("hit_oh0", 32'(mole_onehot), 32'd0);
    chk("hit_valid0", 32'(mole_valid), 32'd0);
    step();
    chk("hit_once", 32'(hit_ok), 32'd0);

    // Wrong hole ignored, then hit on the final timeout cycle
    wait_rise(1'b0, 40, "rise_t4");
    m = int'(moletime);
    hit_valid = 1'b1;
    hit_hole = mole ^ 3'd1;
    step();
    hit_valid = 1'b0;
    chk("wrong_hit", 32'(hit_ok), 32'd0);
    chk("wrong_valid", 32'(mole_valid), 32'd1);
    repeat (4 * m - 2) step();
    chk("last_cycle", 32'(mole_valid), 32'd1);
    hit_valid = 1'b1;
    hit_hole = mole;
    step();
    hit_valid = 1'b0;
    chk("late_hit", 32'(hit_ok), 32'd1);
    chk("late_miss", 32'(miss), 32'd0);
    chk("late_valid", 32'(mole_valid), 32'd0);

    // Abort mid-SHOW
    wait_rise(1'b0, 40, "rise_t6");
    step();
    sv_mole = mole;
    sv_time = moletime;
    enable = 1'b0;
    step();
    chk("abort_valid", 32'(mole_valid), 32'd0);
    chk("abort_miss", 32'(miss), 32'd0);
    chk("abort_past", 32'(pastenable), 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (mole_valid || miss || hit_ok || mole_onehot != 8'd0) bad = 1'b1;
    end
    chk("abort_quiet", 32'(bad), 32'd0);
    chk("abort_mole", 32'(mole), 32'(sv_mole));
    chk("abort_time", 32'(moletime), 32'(sv_time));
    enable = 1'b1;
    step();
    chk("reenable_pick", 32'(mole_valid), 32'd0);
    wait_rise(1'b0, 10, "reenable_rise");

    // Reset mid-SHOW
    reset = 1'b1;
    step();
    chk("rst_valid", 32'(mole_valid), 32'd0);
    chk("rst_miss", 32'(miss), 32'd0);
    chk("rst_mole", 32'(mole), 32'd0);
    chk("rst_lfsr", 32'(u_dut.u_lfsr.lfsr_out), 32'h0000ACE1);
    reset = 1'b0;
    enable = 1'b0;

    // Five holes, 200 picks
    enable5 = 1'b1;
    prev5 = 3'd7;
    for (int k = 0; k < 200; k++) begin
      wait_rise(1'b1, 60, $sformatf("rise5_%0d", k));
      chk($sformatf("range5_%0d", k), 32'(mole5 < 3'd5), 32'd1);
      chk($sformatf("time5_%0d", k), 32'(moletime5 != 3'd0), 32'd1);
      chk($sformatf("oh5_%0d", k), 32'(mole_onehot5), 32'(5'd1 << mole5));
`ifdef MOLE_NO_REPEAT_EN
      if (k > 0) chk($sformatf("norep5_%0d", k), 32'(mole5 != prev5), 32'd1);
`endif
      prev5 = mole5;
      hit_valid5 = 1'b1;
      hit_hole5 = mole5;
      step();
      hit_valid5 = 1'b0;
      chk($sformatf("hit5_%0d", k), 32'(hit_ok5), 32'd1);
    end
    enable5 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
